// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-source uart_send arbiter: FSM state
// encoding and the line-level constants used for the idle indication.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } tx_state_e;

    localparam logic LVL_AVAIL   = 1'b1;
    localparam logic LVL_UNAVAIL = 1'b0;

endpackage

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Two-way round-robin grant. The grant is combinational from the valid
// vector and the pointer; the pointer moves past the winner only when the
// owner of this arbiter accepts the grant.
module uart_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic       grant_o,
    output logic       grant_vld_o
);

    logic ptr_q;
    logic ptr_d;

    // Pointer side wins if it is asking, otherwise the other side.
    always_comb begin
        grant_vld_o = |valid_i;
        grant_o     = valid_i[ptr_q] ? ptr_q : ~ptr_q;
        ptr_d       = accept_i ? ~grant_o : ptr_q;
    end

    // Pointer register; after reset requester 0 has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_send transmitter between two byte sources. One byte is
// granted per frame in round-robin order, latched and held on send_data,
// launched with a send_ce strobe and tracked through send_busy. A frame
// whose busy flag never rises within BUSY_TIMEOUT cycles is dropped.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 16,
    parameter int TO_W         = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       send_ce,
    output logic [7:0] send_data,
    input  logic       send_busy,
    output logic       tx_owner,
    output logic       idle,
    output logic       timeout_err
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(BUSY_TIMEOUT);

    tx_state_e       state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic            owner_q, owner_d;
    logic            rdy0_q, rdy0_d;
    logic            rdy1_q, rdy1_d;
    logic            ce_q, ce_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            grant;
    logic            grant_vld;
    logic            accept;

    uart_rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .valid_i     ({req1_valid, req0_valid}),
        .accept_i    (accept),
        .grant_o     (grant),
        .grant_vld_o (grant_vld)
    );

    // Next-state logic: grant in IDLE, strobe, wait for busy rise/fall, one gap cycle.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        owner_d     = owner_q;
        rdy0_d      = 1'b0;
        rdy1_d      = 1'b0;
        ce_d        = 1'b0;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        timeout_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A busy transmitter seen in IDLE belongs to someone else: hold off.
                if (grant_vld && !send_busy) begin
                    accept  = 1'b1;
                    data_d  = grant ? req1_data : req0_data;
                    rdy0_d  = ~grant;
                    rdy1_d  = grant;
                    owner_d = grant;
                    cnt_d   = '0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // send_ce is registered, so it reaches uart_send one cycle after ready.
                ce_d    = 1'b1;
                cnt_d   = cnt_q + TO_W'(1);
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (send_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == TO_MAX) begin
                    timeout_err = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!send_busy) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched byte and registered handshake/strobe outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            data_q  <= 8'h00;
            owner_q <= 1'b0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            ce_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            ce_q    <= ce_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req0_ready = rdy0_q;
    assign req1_ready = rdy1_q;
    assign send_ce    = ce_q;
    assign send_data  = data_q;
    assign tx_owner   = owner_q;
    assign idle       = ((state_q == ST_IDLE) && !send_busy) ? LVL_AVAIL : LVL_UNAVAIL;

endmodule
